// File: rtl/lock_controller.sv
// -----------------------------------------------------------------------------
// lock_controller
//
// PIN-entry door lock. A four-digit BCD PIN arrives from a keypad decoder as a
// 16-bit word with a one-cycle strobe. A correct PIN unlocks; repeated wrong
// PINs lead to a timed lockout. While unlocked, the PIN can be changed
// (enter new PIN, then confirm it). An inactivity timer relocks the door.
//
// Ports
//   clk_500Hz     in   1   sole clock, all state changes on its rising edge
//   rst           in   1   asynchronous, active-high reset
//   userPin       in  16   submitted PIN, valid only while validPin=1
//   validPin      in   1   single-cycle submit strobe
//   btn_lock      in   1   relock button level (debounced, synchronised)
//   btn_adjust    in   1   change-PIN button level (debounced, synchronised)
//   status        out  2   0=LOCKED 1=UNLOCKED 2=ADJUST 3=LOCKOUT
//   attemptsLeft  out  2   wrong submissions left before lockout
//   okPulse       out  1   one cycle: PIN accepted or new PIN committed
//   failPulse     out  1   one cycle: wrong PIN or confirmation mismatch
//   lockoutSecs   out  4   whole seconds of lockout remaining, rounded up
// -----------------------------------------------------------------------------
module lock_controller #(
    parameter logic [15:0] DEFAULT_PIN   = 16'h1234,
    parameter int          MAX_ATTEMPTS  = 3,
    parameter int          LOCKOUT_TICKS = 5000,
    parameter int          RELOCK_TICKS  = 15000
) (
    input  logic        clk_500Hz,
    input  logic        rst,
    input  logic [15:0] userPin,
    input  logic        validPin,
    input  logic        btn_lock,
    input  logic        btn_adjust,
    output logic [1:0]  status,
    output logic [1:0]  attemptsLeft,
    output logic        okPulse,
    output logic        failPulse,
    output logic [3:0]  lockoutSecs
);

    localparam logic [1:0] ATTEMPTS_INIT = 2'(MAX_ATTEMPTS);

    // The lockout timer is held as (seconds, sub-second) so that the
    // rounded-up seconds display is simply the seconds counter:
    //   timer = (sec_cnt - 1) * 500 + sub_cnt,  sub_cnt in 1..500
    localparam int         LO_SECS_I = (LOCKOUT_TICKS + 499) / 500;
    localparam logic [3:0] LO_SECS   = 4'(LO_SECS_I);
    localparam logic [8:0] LO_SUB    = 9'(LOCKOUT_TICKS - (LO_SECS_I - 1) * 500);
    localparam logic [8:0] SUB_FULL  = 9'd500;

    localparam int            RW          = $clog2(RELOCK_TICKS);
    localparam logic [RW-1:0] RELOCK_LAST = RW'(RELOCK_TICKS - 1);

    typedef enum logic [2:0] {
        S_LOCKED,
        S_UNLOCKED,
        S_ADJ_NEW,
        S_ADJ_CONFIRM,
        S_LOCKOUT
    } state_t;

    state_t        state, state_n;
    logic [15:0]   stored_pin, stored_n;
    logic [15:0]   cand_pin, cand_n;
    logic [1:0]    attempts, att_n;
    logic [3:0]    sec_cnt, sec_n;
    logic [8:0]    sub_cnt, sub_n;
    logic [RW-1:0] relock_cnt, relock_n;
    logic          lock_q, adj_q;
    logic [1:0]    status_r, status_n;
    logic          ok_r, ok_n;
    logic          fail_r, fail_n;

    logic          lock_edge, adj_edge;
    logic          any_event, timed_out;

    function automatic logic [1:0] status_of(input state_t s);
        case (s)
            S_LOCKED:      return 2'd0;
            S_UNLOCKED:    return 2'd1;
            S_ADJ_NEW:     return 2'd2;
            S_ADJ_CONFIRM: return 2'd2;
            S_LOCKOUT:     return 2'd3;
            default:       return 2'd0;
        endcase
    endfunction

    // Only a rising edge of a button acts; holding it does nothing further.
    assign lock_edge = btn_lock & ~lock_q;
    assign adj_edge  = btn_adjust & ~adj_q;
    assign any_event = validPin | lock_edge | adj_edge;
    assign timed_out = (relock_cnt == RELOCK_LAST);

    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            state      <= S_LOCKED;
            stored_pin <= DEFAULT_PIN;
            cand_pin   <= 16'h0000;
            attempts   <= ATTEMPTS_INIT;
            sec_cnt    <= 4'd0;
            sub_cnt    <= 9'd0;
            relock_cnt <= '0;
            lock_q     <= 1'b0;
            adj_q      <= 1'b0;
            status_r   <= 2'd0;
            ok_r       <= 1'b0;
            fail_r     <= 1'b0;
        end else begin
            state      <= state_n;
            stored_pin <= stored_n;
            cand_pin   <= cand_n;
            attempts   <= att_n;
            sec_cnt    <= sec_n;
            sub_cnt    <= sub_n;
            relock_cnt <= relock_n;
            lock_q     <= btn_lock;
            adj_q      <= btn_adjust;
            status_r   <= status_n;
            ok_r       <= ok_n;
            fail_r     <= fail_n;
        end
    end

    always_comb begin
        state_n  = state;
        stored_n = stored_pin;
        cand_n   = cand_pin;
        att_n    = attempts;
        sec_n    = sec_cnt;
        sub_n    = sub_cnt;
        relock_n = '0;
        ok_n     = 1'b0;
        fail_n   = 1'b0;

        // Inactivity timer: runs while unlocked or adjusting, any user
        // activity restarts it. Transitions below override the state.
        if (state == S_UNLOCKED || state == S_ADJ_NEW || state == S_ADJ_CONFIRM) begin
            if (any_event || timed_out) begin
                relock_n = '0;
            end else begin
                relock_n = relock_cnt + 1'b1;
            end
        end

        case (state)
            S_LOCKED: begin
                if (validPin) begin
                    if (userPin == stored_pin) begin
                        state_n = S_UNLOCKED;
                        ok_n    = 1'b1;
                        att_n   = ATTEMPTS_INIT;
                    end else if (attempts > 2'd1) begin
                        fail_n = 1'b1;
                        att_n  = attempts - 2'd1;
                    end else begin
                        state_n = S_LOCKOUT;
                        fail_n  = 1'b1;
                        att_n   = 2'd0;
                        sec_n   = LO_SECS;
                        sub_n   = LO_SUB;
                    end
                end
            end

            // Submissions are ignored here, but still restart the
            // inactivity timer.
            S_UNLOCKED: begin
                if (lock_edge) begin
                    state_n = S_LOCKED;
                end else if (adj_edge) begin
                    state_n = S_ADJ_NEW;
                end else if (!validPin && timed_out) begin
                    state_n = S_LOCKED;
                end
            end

            S_ADJ_NEW: begin
                if (lock_edge) begin
                    state_n = S_LOCKED;
                end else if (validPin) begin
                    cand_n  = userPin;
                    state_n = S_ADJ_CONFIRM;
                end else if (!adj_edge && timed_out) begin
                    state_n = S_LOCKED;
                end
            end

            S_ADJ_CONFIRM: begin
                if (lock_edge) begin
                    state_n = S_LOCKED;
                end else if (validPin) begin
                    state_n = S_UNLOCKED;
                    if (userPin == cand_pin) begin
                        stored_n = cand_pin;
                        ok_n     = 1'b1;
                    end else begin
                        fail_n = 1'b1;
                    end
                end else if (!adj_edge && timed_out) begin
                    state_n = S_LOCKED;
                end
            end

            // The last tick (timer 1 -> 0) leaves lockout, so the seconds
            // counter reaches 0 exactly as the state returns to LOCKED.
            S_LOCKOUT: begin
                if (sec_cnt == 4'd0 || (sec_cnt == 4'd1 && sub_cnt == 9'd1)) begin
                    state_n = S_LOCKED;
                    att_n   = ATTEMPTS_INIT;
                    sec_n   = 4'd0;
                    sub_n   = 9'd0;
                end else if (sub_cnt == 9'd1) begin
                    sec_n = sec_cnt - 4'd1;
                    sub_n = SUB_FULL;
                end else begin
                    sub_n = sub_cnt - 9'd1;
                end
            end

            default: begin
                state_n = S_LOCKED;
            end
        endcase

        status_n = status_of(state_n);
    end

    assign status       = status_r;
    assign attemptsLeft = attempts;
    assign okPulse      = ok_r;
    assign failPulse    = fail_r;
    assign lockoutSecs  = sec_cnt;

endmodule
